// File: rtl/muldiv_pkg.sv
// Shared constants for the MIPS HI/LO multiply/divide unit: op encodings, FSM states, default width.
// Optional build macro MULDIV_FAST_MUL_EN is consumed by muldiv_unit.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   // Divide by zero: LO is filled with this bit, HI returns the dividend unchanged.
   localparam logic DIVZ_LO_FILL = 1'b1;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the datapath (master) and the multiply/divide unit (slave).
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             we_hi;
   logic             we_lo;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srca, srcb, we_hi, we_lo, wd,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, srca, srcb, we_hi, we_lo, wd,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on a 2*WIDTH accumulator.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic                 mulMode_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     operand_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] partial;
   logic [WIDTH:0] diff;

   // Multiply keeps the multiplier in the low half and shifts the product in from the top;
   // divide keeps {remainder, dividend/quotient} and shifts left one quotient bit per step.
   always_comb begin
      sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      partial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff    = partial - {1'b0, operand_i};
      if (mulMode_i) begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
         acc_o = {partial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies (divide stays iterative).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   operand_q, operand_d;
   logic               divOp_q, divOp_d;
   logic               negA_q, negA_d;
   logic               negB_q, negB_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               divOp, signedOp;
   logic               signA, signB;
   logic [WIDTH-1:0]   magA, magB;
   logic [2*WIDTH-1:0] accStep;
   logic               negQ;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quo, rem;
   logic [WIDTH-1:0]   resHi, resLo;

   always_comb begin
      divOp    = 1'b0;
      signedOp = 1'b0;
      case (bus.op)
         OP_MULT:  begin divOp = 1'b0; signedOp = 1'b1; end
         OP_MULTU: begin divOp = 1'b0; signedOp = 1'b0; end
         OP_DIV:   begin divOp = 1'b1; signedOp = 1'b1; end
         OP_DIVU:  begin divOp = 1'b1; signedOp = 1'b0; end
         default:  begin divOp = 1'b0; signedOp = 1'b0; end
      endcase
      signA = signedOp & bus.srca[WIDTH-1];
      signB = signedOp & bus.srcb[WIDTH-1];
      magA  = signA ? -bus.srca : bus.srca;
      magB  = signB ? -bus.srcb : bus.srcb;
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .mulMode_i (!divOp_q),
      .acc_i     (acc_q),
      .operand_i (operand_q),
      .acc_o     (accStep)
   );

   // Negating the remainder magnitude by the dividend sign also restores the original
   // dividend for divide-by-zero, since restoring division leaves it untouched in the top half.
   always_comb begin
      negQ    = negA_q ^ negB_q;
      product = negQ ? -acc_q : acc_q;
      quo     = acc_q[WIDTH-1:0];
      rem     = acc_q[2*WIDTH-1:WIDTH];
      if (divOp_q) begin
         resHi = negA_q ? -rem : rem;
         resLo = (operand_q == '0) ? {WIDTH{DIVZ_LO_FILL}} : (negQ ? -quo : quo);
      end else begin
         resHi = product[2*WIDTH-1:WIDTH];
         resLo = product[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      divOp_d   = divOp_q;
      negA_d    = negA_q;
      negB_d    = negB_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.we_hi) hi_d = bus.wd;
            if (bus.we_lo) lo_d = bus.wd;
            if (bus.start) begin
               divOp_d = divOp;
               negA_d  = signA;
               negB_d  = signB;
               count_d = '0;
               state_d = ST_RUN;
               if (divOp) begin
                  acc_d     = {{WIDTH{1'b0}}, magA};
                  operand_d = magB;
               end else begin
                  acc_d     = {{WIDTH{1'b0}}, magB};
                  operand_d = magA;
               end
`ifdef MULDIV_FAST_MUL_EN
               if (!divOp) begin
                  acc_d   = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
                  state_d = ST_FIX;
               end
`endif
            end
         end
         ST_RUN: begin
            acc_d   = accStep;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            hi_d    = resHi;
            lo_d    = resLo;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         operand_q <= '0;
         divOp_q   <= 1'b0;
         negA_q    <= 1'b0;
         negB_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         divOp_q   <= divOp_d;
         negA_q    <= negA_d;
         negB_q    <= negB_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy = (state_q != ST_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Presents an operation and returns 1 time unit after the edge that samples it (E0).
   task automatic startOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.op    = o;
      bus.srca  = a;
      bus.srcb  = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Counts edges until done is seen, bounded so a dead DUT cannot hang the run.
   task automatic waitDone(output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 00000000", bus.lo); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mthi_mtlo();
      bus.we_hi = 1'b1; bus.wd = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.we_hi = 1'b0;
      checks++; if (bus.hi !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL mthi: got %h expected cafef00d", bus.hi); end
      bus.we_lo = 1'b1; bus.wd = 32'h12345678;
      @(posedge clk); #1;
      bus.we_lo = 1'b0;
      checks++; if (bus.lo !== 32'h12345678) begin errors++; $display("[TB] FAIL mtlo: got %h expected 12345678", bus.lo); end
      checks++; if (bus.hi !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL mtlo_hi_kept: got %h expected cafef00d", bus.hi); end
   endtask

   task automatic test_write_with_start();
      int lat;
      bus.we_hi = 1'b1; bus.wd = 32'hAAAA5555;
      startOp(OP_MULTU, 32'd2, 32'd3);
      bus.we_hi = 1'b0;
      checks++; if (bus.hi !== 32'hAAAA5555) begin errors++; $display("[TB] FAIL wr_start_hi_e0: got %h expected aaaa5555", bus.hi); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_start_busy: got %b expected 1", bus.busy); end
      waitDone(lat);
      checks++; if (lat != MUL_LAT) begin errors++; $display("[TB] FAIL wr_start_latency: got %0d expected %0d", lat, MUL_LAT); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL wr_start_hi: got %h expected 00000000", bus.hi); end
      checks++; if (bus.lo !== 32'd6) begin errors++; $display("[TB] FAIL wr_start_lo: got %h expected 00000006", bus.lo); end
      @(posedge clk); #1;
   endtask

   task automatic test_multiply();
      logic [1:0]   ops[4] = '{OP_MULT, OP_MULT, OP_MULTU, OP_MULT};
      logic [W-1:0] a[4]   = '{32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd6};
      logic [W-1:0] b[4]   = '{32'd5, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'd7};
      logic [W-1:0] eh[4]  = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h0};
      logic [W-1:0] el[4]  = '{32'hFFFFFFF1, 32'd24, 32'h00000001, 32'd42};
      int lat;
      for (int i = 0; i < 4; i++) begin
         startOp(ops[i], a[i], b[i]);
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL mul%0d_busy: got %b expected 1", i, bus.busy); end
         waitDone(lat);
         checks++; if (lat != MUL_LAT) begin errors++; $display("[TB] FAIL mul%0d_latency: got %0d expected %0d", i, lat, MUL_LAT); end
         checks++; if (bus.hi !== eh[i]) begin errors++; $display("[TB] FAIL mul%0d_hi: got %h expected %h", i, bus.hi, eh[i]); end
         checks++; if (bus.lo !== el[i]) begin errors++; $display("[TB] FAIL mul%0d_lo: got %h expected %h", i, bus.lo, el[i]); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mul%0d_busy_in_done: got %b expected 0", i, bus.busy); end
         @(posedge clk); #1;
         checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mul%0d_done_once: got %b expected 0", i, bus.done); end
      end
   endtask

   task automatic test_divide();
      logic [1:0]   ops[6] = '{OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
      logic [W-1:0] a[6]   = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100, 32'hFFFFFFFB, 32'd9};
      logic [W-1:0] b[6]   = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'd0, 32'd0};
      logic [W-1:0] eh[6]  = '{32'hFFFFFFFF, 32'd1, 32'h0, 32'd2, 32'hFFFFFFFB, 32'd9};
      logic [W-1:0] el[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFF};
      int lat;
      for (int i = 0; i < 6; i++) begin
         startOp(ops[i], a[i], b[i]);
         waitDone(lat);
         checks++; if (lat != DIV_LAT) begin errors++; $display("[TB] FAIL div%0d_latency: got %0d expected %0d", i, lat, DIV_LAT); end
         checks++; if (bus.hi !== eh[i]) begin errors++; $display("[TB] FAIL div%0d_hi: got %h expected %h", i, bus.hi, eh[i]); end
         checks++; if (bus.lo !== el[i]) begin errors++; $display("[TB] FAIL div%0d_lo: got %h expected %h", i, bus.lo, el[i]); end
         @(posedge clk); #1;
         checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL div%0d_done_once: got %b expected 0", i, bus.done); end
      end
   endtask

   // Entered with hi=9, lo=ffffffff left by DIVU 9/0.
   task automatic test_busy_ignore();
      int lat;
      int extra;
      startOp(OP_DIVU, 32'd100, 32'd7);
      repeat (9) begin @(posedge clk); #1; end
      bus.start = 1'b1; bus.op = OP_MULTU; bus.srca = 32'd5; bus.srcb = 32'd5;
      bus.we_lo = 1'b1; bus.wd = 32'h1234;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.we_lo = 1'b0;
      checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL busy_we_lo_ignored: got %h expected ffffffff", bus.lo); end
      checks++; if (bus.hi !== 32'd9) begin errors++; $display("[TB] FAIL busy_hi_stable: got %h expected 00000009", bus.hi); end
      waitDone(lat);
      checks++; if (lat + 10 != DIV_LAT) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected %0d", lat + 10, DIV_LAT); end
      checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL busy_lo: got %h expected 0000000e", bus.lo); end
      checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL busy_hi: got %h expected 00000002", bus.hi); end
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("[TB] FAIL busy_no_queue: got %0d active cycles expected 0", extra); end
   endtask

   task automatic test_reset_midop();
      int seen;
      startOp(OP_DIVU, 32'd100, 32'd7);
      repeat (14) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL midrst_hi: got %h expected 00000000", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL midrst_lo: got %h expected 00000000", bus.lo); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", seen); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL midrst_lo_after: got %h expected 00000000", bus.lo); end
   endtask

   task automatic test_back_to_back();
      int lat;
      startOp(OP_MULTU, 32'd3, 32'd4);
      waitDone(lat);
      checks++; if (lat != MUL_LAT) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", lat, MUL_LAT); end
      checks++; if (bus.lo !== 32'd12) begin errors++; $display("[TB] FAIL b2b_first_lo: got %h expected 0000000c", bus.lo); end
      startOp(OP_DIVU, 32'd20, 32'd6);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accepted: got %b expected 1", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", bus.done); end
      waitDone(lat);
      checks++; if (lat != DIV_LAT) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", lat, DIV_LAT); end
      checks++; if (bus.lo !== 32'd3) begin errors++; $display("[TB] FAIL b2b_second_lo: got %h expected 00000003", bus.lo); end
      checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL b2b_second_hi: got %h expected 00000002", bus.hi); end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.srca  = '0;
      bus.srcb  = '0;
      bus.we_hi = 1'b0;
      bus.we_lo = 1'b0;
      bus.wd    = '0;
      test_reset();
      test_mthi_mtlo();
      test_write_with_start();
      test_multiply();
      test_divide();
      test_busy_ignore();
      test_reset_midop();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
